axi_lite_slave_regfile: RTL and testbench
=========================================

# axi_lite_slave_regfile

AXI-Lite responder that terminates one slave port of the interconnect: it accepts write/read transactions routed to it by `axi_lite_decoder` and serves them from an internal bank of 32-bit registers. It is the slave end of the same AXI-Lite link the decoder steers. Register contents are also exported as a flat bus for use by local hardware.

## Interface
- `NUM_REGS`, 8: number of 32-bit registers; legal range 1..16384.
- `ADDR_WIDTH`, 32: width of `i_axi_awaddr` and `i_axi_araddr`.
- `clk`  in  1: single clock; all logic on the rising edge.
- `resetn`  in  1: synchronous, active-low reset.
- `i_axi_awaddr`  in  ADDR_WIDTH: write address.
- `i_axi_awvalid`  in  1 / `o_axi_awready`  out  1: AW handshake.
- `i_axi_wdata`  in  32, `i_axi_wstrb`  in  4: write data and byte strobes.
- `i_axi_wvalid`  in  1 / `o_axi_wready`  out  1: W handshake.
- `o_axi_bresp`  out  2, `o_axi_bvalid`  out  1, `i_axi_bready`  in  1: B channel.
- `i_axi_araddr`  in  ADDR_WIDTH: read address.
- `i_axi_arvalid`  in  1 / `o_axi_arready`  out  1: AR handshake.
- `o_axi_rdata`  out  32, `o_axi_rresp`  out  2, `o_axi_rvalid`  out  1, `i_axi_rready`  in  1: R channel.
- `o_regs`  out  NUM_REGS*32: register bank; register k occupies bits [32k+31:32k].

## Operation
- Word index is `addr[15:2]`. Bits [1:0] are ignored, so unaligned accesses hit the containing word. Bits above 15 are ignored because decoding is done upstream.
- An index of `NUM_REGS` or greater is out of range: the response is SLVERR (2'b10), writes are dropped, and reads return 0. An in-range access returns OKAY (2'b00).
- **Write path:** AW and W are captured independently in one-entry holding buffers (`aw_full`, `w_full`). Either may arrive first, or both may arrive in the same cycle.
  - `o_axi_awready = resetn & ~aw_full & ~o_axi_bvalid`.
  - `o_axi_wready = resetn & ~w_full & ~o_axi_bvalid`.
  - **Commit cycle:** the first cycle in which address and data are both available, each either held or handshaking that cycle. At the end of that cycle:
    - bytes with `wstrb[i]`=1 update byte i of the register; bytes with `wstrb[i]`=0 are unchanged;
    - both buffers are cleared;
    - `o_axi_bvalid` rises and `o_axi_bresp` is set.
  - `o_axi_bvalid` and `o_axi_bresp` hold stable until the cycle in which `i_axi_bready`=1, then `o_axi_bvalid` clears at that edge.
  - No new AW or W is accepted while `o_axi_bvalid`=1, so there is at most one outstanding write.
- **Read path:** two states, R_IDLE and R_DATA.
  - R_IDLE: `o_axi_arready = resetn`. An AR handshake samples the register and captures `o_axi_rdata` and `o_axi_rresp` at that edge, then moves to R_DATA with `o_axi_rvalid`=1.
  - R_DATA: `o_axi_arready`=0. rdata, rresp and rvalid hold stable until `i_axi_rready`=1, then the block returns to R_IDLE with rvalid=0.
- **Read and write together:** the read and write paths are fully independent. If an AR handshake and a write commit to the same register fall in the same cycle, the read returns the pre-write value.
- `o_regs` reflects the register bank directly, with no extra delay after the commit edge.

## Timing
- Reset value of every output while `resetn`=0:
  - `o_axi_awready`, `o_axi_wready`, `o_axi_arready` = 0;
  - `o_axi_bvalid`, `o_axi_rvalid` = 0;
  - `o_axi_bresp`, `o_axi_rresp` = 2'b00;
  - `o_axi_rdata` = 0; all registers and `o_regs` = 0.
- Holding buffers clear and the read FSM returns to R_IDLE on reset.
- Reset asserted mid-transaction abandons it: a pending B or R response is dropped and a partially captured AW or W is discarded.
- The ready signals rise combinationally in the first cycle with `resetn`=1.
- **Write latency:** if AW and W handshake in cycle n, the register updates and BVALID is 1 in cycle n+1. With `i_axi_bready` held high, the next AW/W is accepted in cycle n+2. Peak rate is one write per 2 cycles.
- **Split write:** AW in cycle n and W in cycle n+3 give a commit in n+3 and BVALID in n+4.
- **Read latency:** AR in cycle n gives RVALID in n+1. With `i_axi_rready` high, ARREADY returns in n+2. Peak rate is one read per 2 cycles.
- **Backpressure:**
  - With BREADY low, BVALID/BRESP hold indefinitely and AWREADY/WREADY stay 0.
  - With RREADY low, RVALID/RDATA/RRESP hold indefinitely and ARREADY stays 0.

## Test plan
- **Reset:** hold `resetn`=0 for 2 cycles. All outputs must be 0, all readies must be 0, and `o_regs`=0. After release, AWREADY, WREADY and ARREADY must be 1 in the same cycle.
- **Full write, simultaneous AW/W:** AW=0x0111_0004, W=0xDEAD_BEEF, wstrb=4'hF in the same cycle. Next cycle: BVALID=1, BRESP=0, `o_regs[63:32]`=0xDEADBEEF. Then read AR=0x0211_0004: RDATA=0xDEADBEEF, RRESP=0.
- **Split, reversed order:** W=0x1234_5678 with wstrb=4'b0101 in cycle n, AW=0x0 in n+2. WREADY must be 0 in n+1..n+2. Register 0 ends as 0x0034_0078 from a zero start, with BVALID in n+3.
- **Out of range (`NUM_REGS`=8):** write to 0x20 gives BRESP=2'b10 and no register changes. Read of 0x3C gives RRESP=2'b10, RDATA=0.
- **Backpressure:** hold BREADY=0 for 5 cycles after a write. BVALID and BRESP must stay stable and AWREADY/WREADY must stay 0; the next write is accepted only after the B handshake. Repeat with RREADY=0 on the read path.
- **Same-cycle hazard and mid-reset:** register 1 = 0xAAAA_AAAA, then a commit of 0x5555_5555 to it in the same cycle as an AR to 0x4. RDATA must be 0xAAAAAAAA, and register 1 is 0x55555555 afterwards. Then issue AW without W and pulse `resetn` low: BVALID must never rise, and a subsequent lone W must not commit.

Source files
------------

// File: rtl/axi_lite_slave_regfile.sv
// AXI-Lite slave terminating one decoder port with a bank of 32-bit registers.
// Writes pair an address and a data beat (in either order) before committing;
// reads are served by a two-state responder. The bank is also exported flat.
module axi_lite_slave_regfile #(
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [ADDR_WIDTH-1:0]    i_axi_awaddr,
    input  logic                     i_axi_awvalid,
    output logic                     o_axi_awready,
    input  logic [31:0]              i_axi_wdata,
    input  logic [3:0]               i_axi_wstrb,
    input  logic                     i_axi_wvalid,
    output logic                     o_axi_wready,
    output logic [1:0]               o_axi_bresp,
    output logic                     o_axi_bvalid,
    input  logic                     i_axi_bready,
    input  logic [ADDR_WIDTH-1:0]    i_axi_araddr,
    input  logic                     i_axi_arvalid,
    output logic                     o_axi_arready,
    output logic [31:0]              o_axi_rdata,
    output logic [1:0]               o_axi_rresp,
    output logic                     o_axi_rvalid,
    input  logic                     i_axi_rready,
    output logic [NUM_REGS*32-1:0]   o_regs
);

    localparam logic [1:0]  LP_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  LP_RESP_SLVERR = 2'b10;
    // One bit wider than the word index so NUM_REGS = 16384 is representable.
    localparam logic [14:0] LP_NUM_REGS    = 15'(NUM_REGS);

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // Write-side holding buffers and response
    logic        r_aw_full;
    logic [13:0] r_aw_idx;
    logic        r_w_full;
    logic [31:0] r_w_data;
    logic [3:0]  r_w_strb;
    logic        r_bvalid;
    logic [1:0]  r_bresp;

    // Register bank
    logic [31:0] r_regs [NUM_REGS];

    // Read responder
    r_state_t    r_rstate;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic        r_rvalid;

    logic        w_awready;
    logic        w_wready;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_commit;
    logic [13:0] w_wr_idx;
    logic [31:0] w_wr_data;
    logic [3:0]  w_wr_strb;
    logic        w_wr_in_range;
    logic [13:0] w_rd_idx;
    logic        w_rd_in_range;
    logic [31:0] w_rd_data;
    logic        w_unused_addr;

    // Only the word index [15:2] is decoded; the rest of each address is ignored.
    assign w_unused_addr = ^{i_axi_awaddr, i_axi_araddr};

    // Readies drop with resetn so nothing is accepted while in reset.
    assign w_awready = resetn & ~r_aw_full & ~r_bvalid;
    assign w_wready  = resetn & ~r_w_full  & ~r_bvalid;
    assign w_aw_hs   = i_axi_awvalid & w_awready;
    assign w_w_hs    = i_axi_wvalid  & w_wready;

    // Commit as soon as both halves are present, whether held or arriving now.
    assign w_commit      = (r_aw_full | w_aw_hs) & (r_w_full | w_w_hs);
    assign w_wr_idx      = r_aw_full ? r_aw_idx : i_axi_awaddr[15:2];
    assign w_wr_data     = r_w_full  ? r_w_data : i_axi_wdata;
    assign w_wr_strb     = r_w_full  ? r_w_strb : i_axi_wstrb;
    assign w_wr_in_range = {1'b0, w_wr_idx} < LP_NUM_REGS;

    assign w_rd_idx      = i_axi_araddr[15:2];
    assign w_rd_in_range = {1'b0, w_rd_idx} < LP_NUM_REGS;

    // Read mux over the bank; out-of-range indices match nothing and read as 0.
    always_comb begin
        // NOTE: default first so every path assigns w_rd_data and no latch is inferred.
        w_rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_rd_idx == 14'(k)) begin
                w_rd_data = r_regs[k];
            end
        end
    end

    // AW/W holding buffers and B response.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            r_aw_full <= 1'b0;
            r_aw_idx  <= '0;
            r_w_full  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= LP_RESP_OKAY;
        end else begin
            if (w_commit) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_in_range ? LP_RESP_OKAY : LP_RESP_SLVERR;
            end else begin
                if (w_aw_hs) begin
                    r_aw_full <= 1'b1;
                    r_aw_idx  <= i_axi_awaddr[15:2];
                end
                if (w_w_hs) begin
                    r_w_full <= 1'b1;
                    r_w_data <= i_axi_wdata;
                    r_w_strb <= i_axi_wstrb;
                end
                if (r_bvalid && i_axi_bready) begin
                    r_bvalid <= 1'b0;
                end
            end
        end
    end

    // Register bank: byte-strobed update on commit to an in-range index.
    always_ff @(posedge clk) begin
        // NOTE: the bank is plain flops with a defined reset value, so resetting it is intended.
        if (!resetn) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_commit && (w_wr_idx == 14'(k)) && w_wr_strb[b]) begin
                        r_regs[k][8*b +: 8] <= w_wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read responder: capture on AR, hold until R handshake.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rstate <= R_IDLE;
            r_rdata  <= '0;
            r_rresp  <= LP_RESP_OKAY;
            r_rvalid <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (i_axi_arvalid) begin
                        r_rdata  <= w_rd_data;
                        r_rresp  <= w_rd_in_range ? LP_RESP_OKAY : LP_RESP_SLVERR;
                        r_rvalid <= 1'b1;
                        r_rstate <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (i_axi_rready) begin
                        r_rvalid <= 1'b0;
                        r_rstate <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign o_axi_awready = w_awready;
    assign o_axi_wready  = w_wready;
    assign o_axi_bvalid  = r_bvalid;
    assign o_axi_bresp   = r_bresp;
    assign o_axi_arready = resetn & (r_rstate == R_IDLE);
    assign o_axi_rvalid  = r_rvalid;
    assign o_axi_rdata   = r_rdata;
    assign o_axi_rresp   = r_rresp;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
        assign o_regs[32*g +: 32] = r_regs[g];
    end

endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// Bench for axi_lite_slave_regfile: transaction-level model with per-cycle
// comparison, directed scenarios with literal expectations, then random traffic.
module tb_axi_lite_slave_regfile;

    localparam int NUM = 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic [31:0]   awaddr;
    logic          awvalid;
    logic          o_awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          o_wready;
    logic [1:0]    o_bresp;
    logic          o_bvalid;
    logic          bready;
    logic [31:0]   araddr;
    logic          arvalid;
    logic          o_arready;
    logic [31:0]   o_rdata;
    logic [1:0]    o_rresp;
    logic          o_rvalid;
    logic          rready;
    logic [NUM*32-1:0] o_regs;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    axi_lite_slave_regfile #(.NUM_REGS(NUM), .ADDR_WIDTH(32)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .i_axi_awaddr  (awaddr),
        .i_axi_awvalid (awvalid),
        .o_axi_awready (o_awready),
        .i_axi_wdata   (wdata),
        .i_axi_wstrb   (wstrb),
        .i_axi_wvalid  (wvalid),
        .o_axi_wready  (o_wready),
        .o_axi_bresp   (o_bresp),
        .o_axi_bvalid  (o_bvalid),
        .i_axi_bready  (bready),
        .i_axi_araddr  (araddr),
        .i_axi_arvalid (arvalid),
        .o_axi_arready (o_arready),
        .o_axi_rdata   (o_rdata),
        .o_axi_rresp   (o_rresp),
        .o_axi_rvalid  (o_rvalid),
        .i_axi_rready  (rready),
        .o_regs        (o_regs)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed { logic [31:0] d; logic [3:0] s; } wbeat_t;
    typedef struct packed { logic [31:0] d; logic [1:0] resp; } rbeat_t;

    logic [31:0] m_regs [NUM];
    int          m_aw_q [$];
    wbeat_t      m_w_q  [$];
    logic [1:0]  m_b_q  [$];
    rbeat_t      m_r_q  [$];
    bit          m_live = 0;
    bit          m_rst_last = 0;

    // Compare DUT against the model on each falling edge, advance the model on each rising edge.
    initial begin : compare
        logic [255:0] flat;
        bit aw_rdy, w_rdy, ar_rdy;
        int idx;
        wbeat_t wb;
        forever begin
            @(negedge clk);
            if (m_live) begin
                check("awready", o_awready, resetn && m_aw_q.size() == 0 && m_b_q.size() == 0);
                check("wready",  o_wready,  resetn && m_w_q.size()  == 0 && m_b_q.size() == 0);
                check("arready", o_arready, resetn && m_r_q.size() == 0);
                check("bvalid",  o_bvalid,  m_b_q.size() != 0);
                check("rvalid",  o_rvalid,  m_r_q.size() != 0);
                if (m_b_q.size() != 0) check("bresp", o_bresp, m_b_q[0]);
                else if (m_rst_last)   check("bresp_rst", o_bresp, 2'b00);
                if (m_r_q.size() != 0) begin
                    check("rdata", o_rdata, m_r_q[0].d);
                    check("rresp", o_rresp, m_r_q[0].resp);
                end else if (m_rst_last) begin
                    check("rdata_rst", o_rdata, 32'h0);
                    check("rresp_rst", o_rresp, 2'b00);
                end
                flat = '0;
                for (int k = 0; k < NUM; k++) flat[32*k +: 32] = m_regs[k];
                check("o_regs", o_regs, flat);
            end
            @(posedge clk);
            if (!resetn) begin
                m_live = 1;
                m_rst_last = 1;
                m_aw_q.delete(); m_w_q.delete(); m_b_q.delete(); m_r_q.delete();
                for (int k = 0; k < NUM; k++) m_regs[k] = '0;
            end else if (m_live) begin
                m_rst_last = 0;
                aw_rdy = m_aw_q.size() == 0 && m_b_q.size() == 0;
                w_rdy  = m_w_q.size()  == 0 && m_b_q.size() == 0;
                ar_rdy = m_r_q.size() == 0;
                if (m_b_q.size() != 0 && bready) void'(m_b_q.pop_front());
                if (m_r_q.size() != 0 && rready) void'(m_r_q.pop_front());
                // Reads see the bank as it was before any write landing at this edge.
                if (arvalid && ar_rdy) begin
                    idx = int'(araddr[15:2]);
                    if (idx < NUM) m_r_q.push_back('{d: m_regs[idx], resp: 2'b00});
                    else           m_r_q.push_back('{d: 32'h0,       resp: 2'b10});
                end
                if (awvalid && aw_rdy) m_aw_q.push_back(int'(awaddr[15:2]));
                if (wvalid && w_rdy)   m_w_q.push_back('{d: wdata, s: wstrb});
                if (m_aw_q.size() != 0 && m_w_q.size() != 0) begin
                    idx = m_aw_q.pop_front();
                    wb  = m_w_q.pop_front();
                    if (idx < NUM) begin
                        for (int b = 0; b < 4; b++)
                            if (wb.s[b]) m_regs[idx][8*b +: 8] = wb.d[8*b +: 8];
                        m_b_q.push_back(2'b00);
                    end else begin
                        m_b_q.push_back(2'b10);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [31:0] a);
        bit go;
        awaddr = a; awvalid = 1'b1;
        for (int t = 0; t < 200 && awvalid; t++) begin
            @(negedge clk); go = o_awready;
            step();
            if (go) awvalid = 1'b0;
        end
        check("aw_accepted", awvalid, 1'b0);
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        bit go;
        wdata = d; wstrb = s; wvalid = 1'b1;
        for (int t = 0; t < 200 && wvalid; t++) begin
            @(negedge clk); go = o_wready;
            step();
            if (go) wvalid = 1'b0;
        end
        check("w_accepted", wvalid, 1'b0);
        wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        bit go;
        araddr = a; arvalid = 1'b1;
        for (int t = 0; t < 200 && arvalid; t++) begin
            @(negedge clk); go = o_arready;
            step();
            if (go) arvalid = 1'b0;
        end
        check("ar_accepted", arvalid, 1'b0);
        arvalid = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] rnd;
        rnd = $urandom();
        return {rnd[31:16], 14'($urandom_range(0, 11)), rnd[1:0]};
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        logic [255:0] exp_regs;
        bit done;
        resetn = 1'b0; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;

        // Reset held for two edges: everything zero.
        step(); step();
        @(negedge clk);
        check("rst_awready", o_awready, 1'b0);
        check("rst_wready",  o_wready,  1'b0);
        check("rst_arready", o_arready, 1'b0);
        check("rst_bvalid",  o_bvalid,  1'b0);
        check("rst_rvalid",  o_rvalid,  1'b0);
        check("rst_rdata",   o_rdata,   32'h0);
        check("rst_regs",    o_regs,    256'h0);
        step(); resetn = 1'b1;
        @(negedge clk);
        check("rel_readies", {o_awready, o_wready, o_arready}, 3'b111);
        bready = 1'b1; rready = 1'b1;

        // Simultaneous AW/W full-word write to register 1, then read it back.
        step();
        awaddr = 32'h0111_0004; awvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
        step(); awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        check("wr1_bvalid", o_bvalid, 1'b1);
        check("wr1_bresp",  o_bresp,  2'b00);
        check("wr1_reg1",   o_regs[63:32], 32'hDEAD_BEEF);
        step(); araddr = 32'h0211_0004; arvalid = 1'b1;
        step(); arvalid = 1'b0;
        @(negedge clk);
        check("rd1_rvalid", o_rvalid, 1'b1);
        check("rd1_rdata",  o_rdata,  32'hDEAD_BEEF);
        check("rd1_rresp",  o_rresp,  2'b00);

        // W first with partial strobes, AW two cycles later.
        step(); wdata = 32'h1234_5678; wstrb = 4'b0101; wvalid = 1'b1;
        step(); wvalid = 1'b0;
        @(negedge clk);
        check("split_wready_n1", o_wready, 1'b0);
        step(); awaddr = 32'h0; awvalid = 1'b1;
        @(negedge clk);
        check("split_wready_n2", o_wready, 1'b0);
        check("split_bvalid_n2", o_bvalid, 1'b0);
        step(); awvalid = 1'b0;
        @(negedge clk);
        check("split_bvalid_n3", o_bvalid, 1'b1);
        check("split_reg0", o_regs[31:0], 32'h0034_0078);

        // Out-of-range write and read.
        step(); awaddr = 32'h20; awvalid = 1'b1; wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
        step(); awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        exp_regs = '0;
        exp_regs[63:32] = 32'hDEAD_BEEF;
        exp_regs[31:0]  = 32'h0034_0078;
        check("oor_bresp", o_bresp, 2'b10);
        check("oor_regs",  o_regs,  exp_regs);
        step(); araddr = 32'h3C; arvalid = 1'b1;
        step(); arvalid = 1'b0;
        @(negedge clk);
        check("oor_rresp", o_rresp, 2'b10);
        check("oor_rdata", o_rdata, 32'h0);

        // B backpressure: a second write waits for the B handshake.
        step(); bready = 1'b0;
        awaddr = 32'h8; awvalid = 1'b1; wdata = 32'hC3; wstrb = 4'hF; wvalid = 1'b1;
        step(); awaddr = 32'hC; wdata = 32'h77;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_bvalid",  o_bvalid, 1'b1);
            check("bp_bresp",   o_bresp,  2'b00);
            check("bp_readies", {o_awready, o_wready}, 2'b00);
            step();
        end
        bready = 1'b1;
        step();
        @(negedge clk);
        check("bp_released", {o_awready, o_wready}, 2'b11);
        step(); awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        check("bp_second_bvalid", o_bvalid, 1'b1);
        check("bp_reg3", o_regs[127:96], 32'h77);

        // R backpressure.
        step(); rready = 1'b0; araddr = 32'h8; arvalid = 1'b1;
        step(); arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rbp_rvalid",  o_rvalid,  1'b1);
            check("rbp_rdata",   o_rdata,   32'hC3);
            check("rbp_arready", o_arready, 1'b0);
            step();
        end
        rready = 1'b1;
        step();
        @(negedge clk);
        check("rbp_released", {o_rvalid, o_arready}, 2'b01);

        // Same-cycle write commit and read of register 1.
        step(); awaddr = 32'h4; awvalid = 1'b1; wdata = 32'hAAAA_AAAA; wstrb = 4'hF; wvalid = 1'b1;
        step(); awvalid = 1'b0; wvalid = 1'b0;
        step();
        awaddr = 32'h4; awvalid = 1'b1; wdata = 32'h5555_5555; wvalid = 1'b1;
        araddr = 32'h4; arvalid = 1'b1;
        step(); awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        check("haz_rdata", o_rdata, 32'hAAAA_AAAA);
        check("haz_reg1",  o_regs[63:32], 32'h5555_5555);

        // Lone AW, then reset: the captured address must be discarded.
        step(); awaddr = 32'h8; awvalid = 1'b1;
        step(); awvalid = 1'b0; resetn = 1'b0;
        step(); resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mr_bvalid", o_bvalid, 1'b0);
            step();
        end
        wdata = 32'h99; wstrb = 4'hF; wvalid = 1'b1;
        step(); wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mr_lone_w_bvalid", o_bvalid, 1'b0);
            check("mr_regs", o_regs, 256'h0);
            step();
        end

        // Fresh reset, then randomized traffic with random backpressure.
        resetn = 1'b0;
        step(); step();
        resetn = 1'b1;
        done = 0;
        fork
            begin
                while (!done) begin
                    step();
                    bready = ($urandom_range(0, 3) != 0);
                    rready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        fork
            for (int i = 0; i < 60; i++) begin
                repeat ($urandom_range(0, 3)) step();
                send_aw(rand_addr());
            end
            for (int i = 0; i < 60; i++) begin
                repeat ($urandom_range(0, 3)) step();
                send_w($urandom(), 4'($urandom_range(0, 15)));
            end
            for (int i = 0; i < 60; i++) begin
                repeat ($urandom_range(0, 3)) step();
                send_ar(rand_addr());
            end
        join
        done = 1;
        step();
        bready = 1'b1; rready = 1'b1;
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
